// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI mode constants, master FSM state type and packet-size clamp helper
package spi_pkg;
  localparam logic CPOL = 1'b0;
  localparam logic CPHA = 1'b0;
  localparam logic [1:0] SPI_MODE = {CPOL, CPHA};
  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, DONE} spi_master_state_e;
  function automatic int clamp_pkt_size(input int size, input int nbits);
    return (size == 0 || size > nbits) ? nbits : size;
  endfunction
endpackage

// File: rtl/spi_half_period_timer.sv
// spi_half_period_timer: loadable down-counter (clk, reset, load, load_val in; tick out when the phase expires)
module spi_half_period_timer #(
  parameter int div_w = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [div_w-1:0] load_val,
  output logic             tick
);
  logic [div_w:0] cnt;
  always_ff @(posedge clk)
    if (reset) cnt <= '0;
    else if (load) cnt <= {1'b0, load_val};
    else if (cnt != '0) cnt <= cnt - (div_w+1)'(1);
  assign tick = cnt == '0;
endmodule

// File: rtl/spi_master_core.sv
// spi_master_core: SPI mode-0 MSB-first initiator (send val/rdy/msg + pkt_size/half_div in, recv val/rdy/msg out, cs_n/sclk/mosi out, miso in)
module spi_master_core
  import spi_pkg::*;
#(
  parameter int nbits = 34,
  parameter int div_w = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       send_val,
  output logic                       send_rdy,
  input  logic [nbits-1:0]           send_msg,
  input  logic [$clog2(nbits+1)-1:0] pkt_size,
  input  logic [div_w-1:0]           half_div,
  output logic                       recv_val,
  input  logic                       recv_rdy,
  output logic [nbits-1:0]           recv_msg,
  output logic                       cs_n,
  output logic                       sclk,
  output logic                       mosi,
  input  logic                       miso
);
  localparam int pw = $clog2(nbits + 1);
  spi_master_state_e state, state_next;
  logic [nbits-1:0] sh, ld, mask;
  logic [pw-1:0] n, n_in, bcnt;
  logic [div_w-1:0] hd;
  logic tick, mosi_next;
  assign n_in = pw'(clamp_pkt_size(int'(pkt_size), nbits));
  assign ld = send_msg << (nbits - int'(n_in));
  assign mask = {nbits{1'b1}} >> (nbits - int'(n));
  assign send_rdy = state == IDLE && !reset;
  spi_half_period_timer #(.div_w(div_w)) timer (
    .clk(clk),
    .reset(reset),
    .load(state_next != state),
    .load_val(state == IDLE ? half_div : hd),
    .tick(tick)
  );
  always_ff @(posedge clk) state <= reset ? IDLE : state_next;
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    state_next = send_val ? SETUP : IDLE;
      SETUP:   state_next = tick ? HIGH : SETUP;
      HIGH:    state_next = !tick ? HIGH : bcnt == '0 ? HOLD : LOW;
      LOW:     state_next = tick ? HIGH : LOW;
      HOLD:    state_next = tick ? DONE : HOLD;
      DONE:    state_next = recv_rdy ? IDLE : DONE;
      default: state_next = IDLE;
    endcase
    mosi_next = state == IDLE && send_val ? ld[nbits-1] :
                state == HIGH && state_next == LOW ? sh[nbits-1] :
                state_next inside {IDLE, DONE} ? 1'b0 : mosi;
  end
  always_ff @(posedge clk)
    if (reset) begin
      cs_n <= 1'b1;
      sclk <= SPI_MODE[1];
      mosi <= 1'b0;
      recv_val <= 1'b0;
      recv_msg <= '0;
      sh <= '0;
      n <= '0;
      bcnt <= '0;
      hd <= '0;
    end else begin
      cs_n <= state_next inside {IDLE, DONE};
      sclk <= (state_next == HIGH) ^ SPI_MODE[1];
      mosi <= mosi_next;
      recv_val <= state_next == DONE;
      if (state == IDLE && send_val) begin
        sh <= ld;
        n <= n_in;
        bcnt <= n_in;
        hd <= half_div;
      end
      if (state != HIGH && state_next == HIGH) begin
        sh <= {sh[nbits-2:0], miso};
        bcnt <= bcnt - pw'(1);
      end
      if (state == HOLD && state_next == DONE) recv_msg <= sh & mask;
    end
endmodule

// File: tb/tb_spi_master_core.sv
// tb_spi_master_core: scoreboard bench for spi_master_core with a mode-0 minion model on miso
module tb_spi_master_core;
  localparam int NB = 8;
  localparam int DW = 8;
  localparam int PW = $clog2(NB + 1);
  typedef struct {
    logic [NB-1:0] recv;
    int mosi;
    int n;
    int cs;
    int h;
    string name;
  } exp_t;
  logic clk = 0, reset = 1;
  logic send_val = 0, send_rdy, recv_val, recv_rdy = 0;
  logic [NB-1:0] send_msg = '0, recv_msg;
  logic [PW-1:0] pkt_size = '0;
  logic [DW-1:0] half_div = '0;
  logic cs_n, sclk, mosi, miso = 0;
  exp_t sb[$];
  exp_t e;
  int tests = 0, fails = 0;
  int cs_low, run, rises, mosi_bits, phase_err, mosi_err, hcur = 1, stall_err, spurious = 0;
  logic prev_cs = 1, prev_sclk = 0, prev_mosi = 0, prev_val = 0;
  logic [NB-1:0] held;
  logic [NB-1:0] miso_tx = '0;
  int miso_n = 8, idx = 0, rdy_hold = 0, stall = 0;
  bit started = 0;

  spi_master_core #(.nbits(NB), .div_w(DW)) dut (
    .clk(clk), .reset(reset), .send_val(send_val), .send_rdy(send_rdy),
    .send_msg(send_msg), .pkt_size(pkt_size), .half_div(half_div),
    .recv_val(recv_val), .recv_rdy(recv_rdy), .recv_msg(recv_msg),
    .cs_n(cs_n), .sclk(sclk), .mosi(mosi), .miso(miso)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  always @(cs_n, sclk) begin
    if (cs_n) started = 0;
    else if (!started) begin
      started = 1;
      idx = miso_n - 1;
    end else if (!sclk) idx = idx - 1;
    miso = (!cs_n && idx >= 0 && idx < NB) ? miso_tx[idx] : 1'b0;
  end

  always @(posedge clk) begin
    #2;
    if (recv_val && !recv_rdy) begin
      if (stall >= rdy_hold) recv_rdy = 1;
      else stall++;
    end else begin
      recv_rdy = 0;
      stall = 0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (reset) begin
      prev_cs = 1;
      prev_sclk = 0;
      prev_val = 0;
    end else begin
      if (!cs_n) begin
        if (prev_cs) begin
          cs_low = 1; run = 1; rises = 0; mosi_bits = 0; phase_err = 0; mosi_err = 0;
          hcur = sb.size() != 0 ? sb[0].h : 1;
        end else begin
          cs_low++;
          if (sclk != prev_sclk) begin
            if (run != hcur) phase_err++;
            run = 1;
            if (sclk) begin
              rises++;
              mosi_bits = (mosi_bits << 1) | int'(mosi);
            end
          end else begin
            run++;
            if (sclk && mosi != prev_mosi) mosi_err++;
          end
        end
      end else if (!prev_cs && run != hcur) phase_err++;
      if (recv_val && !prev_val) begin
        if (sb.size() == 0) begin
          spurious++;
          chk("spurious_recv_val", 1, 0);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_recv_msg"}, int'(recv_msg), int'(e.recv));
          chk({e.name, "_mosi_bits"}, mosi_bits, e.mosi);
          chk({e.name, "_sclk_rises"}, rises, e.n);
          chk({e.name, "_cs_low_cycles"}, cs_low, e.cs);
          chk({e.name, "_phase_len_errs"}, phase_err, 0);
          chk({e.name, "_mosi_change_high"}, mosi_err, 0);
          held = recv_msg;
          stall_err = int'(send_rdy);
        end
      end else if (recv_val && (recv_msg != held || send_rdy)) stall_err++;
      if (prev_val && recv_rdy) begin
        chk("rdy_after_done", int'({send_rdy, recv_val}), 2);
        chk("stall_stable", stall_err, 0);
      end
      prev_cs = cs_n;
      prev_sclk = sclk;
      prev_mosi = mosi;
      prev_val = recv_val;
    end
  end

  task automatic send(input logic [NB-1:0] msg, input logic [PW-1:0] ps, input logic [DW-1:0] hd,
                      input logic [NB-1:0] mtx, input int n, input bit push,
                      input logic [NB-1:0] exp_recv, input int exp_mosi, input string name);
    int t = 0;
    while (!cs_n && t < 5000) begin
      @(posedge clk); #2; t++;
    end
    miso_tx = mtx;
    miso_n = n;
    send_msg = msg; pkt_size = ps; half_div = hd; send_val = 1;
    while (!send_rdy && t < 5000) begin
      @(posedge clk); #2; t++;
    end
    if (t >= 5000) chk({name, "_send_timeout"}, t, 0);
    if (push) sb.push_back('{exp_recv, exp_mosi, n, (int'(hd) + 1) * (2 * n + 1), int'(hd) + 1, name});
    @(posedge clk); #2;
    send_val = 0;
    send_msg = NB'($urandom);
    pkt_size = PW'($urandom);
    half_div = DW'($urandom);
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || recv_val) && t < 5000) begin
      @(posedge clk); #2; t++;
    end
    chk("drain_pending", sb.size(), 0);
  endtask

  initial begin
    int r, t;
    logic ps;
    repeat (2) @(posedge clk);
    #1;
    chk("rdy_in_reset", int'(send_rdy), 0);
    chk("reset_cs_n", int'(cs_n), 1);
    chk("reset_sclk", int'(sclk), 0);
    chk("reset_mosi", int'(mosi), 0);
    chk("reset_recv_val", int'(recv_val), 0);
    chk("reset_recv_msg", int'(recv_msg), 0);
    #1 reset = 0;
    @(posedge clk); #1;
    chk("rdy_after_reset", int'(send_rdy), 1);
    #1;
    send(8'hA5, 4'd8, 8'd0, 8'h3C, 8, 1, 8'h3C, 'hA5, "t1");
    send(8'h0B, 4'd4, 8'd0, 8'h0F, 4, 1, 8'h0F, 'hB, "t2");
    send(8'h5A, 4'd8, 8'd3, 8'hC3, 8, 1, 8'hC3, 'h5A, "t3");
    rdy_hold = 10;
    send(8'h96, 4'd8, 8'd1, 8'h69, 8, 1, 8'h69, 'h96, "t4a");
    send(8'hF7, 4'd3, 8'd0, 8'h05, 3, 1, 8'h05, 'h7, "t4b");
    drain();
    rdy_hold = 0;
    send(8'hA5, 4'd8, 8'd3, 8'hFF, 8, 0, 8'h00, 0, "t5");
    r = 0; t = 0; ps = sclk;
    while (r < 3 && t < 500) begin
      @(posedge clk); #2;
      if (sclk && !ps) r++;
      ps = sclk;
      t++;
    end
    chk("t5_in_third_high", int'(sclk), 1);
    reset = 1;
    @(posedge clk); #1;
    chk("t5_abort_cs_n", int'(cs_n), 1);
    chk("t5_abort_sclk", int'(sclk), 0);
    chk("t5_abort_mosi", int'(mosi), 0);
    chk("t5_rdy_in_reset", int'(send_rdy), 0);
    #1 reset = 0;
    @(posedge clk); #1;
    chk("t5_rdy_after_reset", int'(send_rdy), 1);
    #1;
    repeat (40) @(posedge clk);
    #2;
    chk("t5_no_recv_val", spurious, 0);
    send(8'h81, 4'd0, 8'd0, 8'h00, 8, 1, 8'h00, 'h81, "t6a");
    send(8'h81, 4'd11, 8'd0, 8'h00, 8, 1, 8'h00, 'h81, "t6b");
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/spi_master_core.md
Name: spi_master_core

Overview:
SPI initiator (SPI mode 0: CPOL=0, CPHA=0, MSB-first) that generates cs_n, sclk and mosi, and samples miso. It is the far-end counterpart of our SPI minion, whose input synchronizer samples these same lines.
- Host side: val/rdy request (send) and response (recv) interfaces.
- Full duplex: each transaction shifts pkt_size bits out and captures pkt_size bits in.
- Used by test harnesses and SoC-side controllers to drive the SPI minion.

Parameters:
nbits, 34, maximum packet width in bits (≥2)
div_w, 8, width of the sclk half-period divider input

Ports:
clk  in  1  device clock
reset  in  1  synchronous, active-high reset
send_val  in  1  request valid
send_rdy  out  1  request ready
send_msg  in  nbits  data to transmit, right-justified (bit pkt_size-1 goes first)
pkt_size  in  $clog2(nbits+1)  bits in this transaction; sampled on request handshake
half_div  in  div_w  sclk half-period = half_div+1 clk cycles; sampled on request handshake
recv_val  out  1  response valid
recv_rdy  in  1  response ready
recv_msg  out  nbits  captured miso bits, right-justified, zero-extended
cs_n  out  1  chip select, active low
sclk  out  1  SPI clock
mosi  out  1  master out
miso  in  1  master in; the minion's clock domain is assumed slow relative to clk, no internal synchronizer

Behaviour:
- Reset is synchronous, active-high, on clock clk.
- Reset values: send_rdy=0 during reset, then 1. recv_val=0, recv_msg=0, cs_n=1, sclk=0, mosi=0, FSM=IDLE.
- Let H = latched half_div+1. Let N = latched pkt_size, with 0 treated as nbits and values >nbits clamped to nbits.
- Handshake: a transfer occurs when val&rdy are both high in the same cycle.
- send_rdy=1 only in IDLE. recv_val=1 only in DONE.
- No request is accepted while a response is pending.
- IDLE
  - On send handshake: latch send_msg left-aligned into the shift register (msg << (nbits-N)), latch N, H and bit counter = N.
  - Next cycle: cs_n=0, mosi = first bit, go to SETUP.
- SETUP
  - sclk=0 for H cycles, then go to HIGH.
- HIGH
  - On entry: sclk=1 and sample miso into the shift register LSB (shift left).
  - Decrement the bit counter.
  - Stays H cycles.
  - Exit: if counter==0 go to HOLD, else go to LOW.
- LOW
  - On entry: sclk=0 and mosi = next bit (shift register MSB after the shift).
  - Stays H cycles, then go to HIGH.
- HOLD
  - sclk=0, cs_n=0 for H cycles.
  - Then cs_n=1, mosi=0, recv_msg = low N bits of the shift register (zero-extended), recv_val=1, go to DONE.
- DONE
  - Hold recv_msg and recv_val stable until recv_rdy.
  - On handshake: recv_val=0 and go to IDLE; send_rdy=1 in the following cycle.
- Timing
  - cs_n low for exactly H*(2N+1) cycles: setup H, N high phases, N-1 low phases, hold H.
  - Exactly N rising edges of sclk.
  - mosi is stable for ≥H cycles before each rising edge.
- Half-period counter: down-counter of width div_w+1; half_div=0 toggles sclk every cycle.
- Reset mid-transaction: next cycle cs_n=1, sclk=0, mosi=0. The transaction is discarded and no recv_val is produced.
- Inputs send_msg, pkt_size and half_div are ignored outside the request handshake.

Decomposition:
- Package spi_pkg:
  - State typedef spi_master_state_e {IDLE, SETUP, HIGH, LOW, HOLD, DONE}.
  - Function clamp_pkt_size.
  - Mode constants (CPOL=0, CPHA=0) shared with the minion side.
- Sub-module spi_half_period_timer:
  - Loadable down-counter.
  - Output tick when the current phase expires.
- Shift register and bit counter stay in spi_master_core.

Test Plan:
1. nbits=8, N=8, half_div=0, send 0xA5; minion model drives miso with 0x3C MSB-first on falling edges.
   → mosi at rising edges is 1,0,1,0,0,1,0,1.
   → recv_msg=0x3C.
   → cs_n low for 17 cycles.
   → 8 sclk rising edges.
2. N=4, send 0x0B, miso held 1.
   → mosi 1,0,1,1.
   → recv_msg=0x0F.
   → 4 rising edges.
   → cs_n low 9 cycles.
3. half_div=3, N=8.
   → each sclk high/low phase is 4 cycles.
   → cs_n low 68 cycles.
   → mosi changes only while sclk=0.
4. recv_rdy held 0 for 10 cycles after recv_val.
   → recv_val, recv_msg stable and send_rdy=0 throughout.
   → after the handshake, send_rdy=1 next cycle; back-to-back request accepted.
5. Reset asserted during the 3rd HIGH phase.
   → next cycle cs_n=1, sclk=0, mosi=0, send_rdy=1 after reset drops.
   → no recv_val ever.
6. pkt_size=0 and pkt_size=nbits+3 (nbits=8), send 0x81, miso=0.
   → both run 8 bits, mosi 1,0,0,0,0,0,0,1, recv_msg=0x00.
